// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back formatter: sub-word load extraction,
// misaligned-load detection, register-file write port and retired-instruction counter.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_wt,
    input  logic [4:0]  mem_wt_addr,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  mem_load_type,
    output logic        wt,
    output logic [4:0]  reg_wt_addr,
    output logic [31:0] Data_in,
    output logic        fwd_valid,
    output logic        ade_l,
    output logic [31:0] bad_vaddr,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        LT_NONE = 3'd0,
        LT_LB   = 3'd1,
        LT_LBU  = 3'd2,
        LT_LH   = 3'd3,
        LT_LHU  = 3'd4,
        LT_LW   = 3'd5,
        LT_RSV6 = 3'd6,
        LT_RSV7 = 3'd7
    } load_e;

    load_e       ld_type;
    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] data_d;
    logic        misal_d;
    logic        retire;
    logic [31:0] instret_d;

    logic        valid_q;
    logic        wt_req_q;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic        misal_q;
    logic [31:0] vaddr_q;
    logic [31:0] instret_q;

    assign ld_type = load_e'(mem_load_type);
    assign off     = mem_alu_result[1:0];

    // Big-endian lanes: offset 0 addresses the most significant byte.
    always_comb begin
        byte_sel = '0;
        case (off)
            2'd0: byte_sel = mem_rdata[31:24];
            2'd1: byte_sel = mem_rdata[23:16];
            2'd2: byte_sel = mem_rdata[15:8];
            2'd3: byte_sel = mem_rdata[7:0];
            default: byte_sel = '0;
        endcase
        half_sel = off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    end

    always_comb begin
        data_d  = mem_alu_result;
        misal_d = 1'b0;
        case (ld_type)
            LT_LB:  data_d = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU: data_d = {24'd0, byte_sel};
            LT_LH: begin
                data_d  = {{16{half_sel[15]}}, half_sel};
                misal_d = off[0];
            end
            LT_LHU: begin
                data_d  = {16'd0, half_sel};
                misal_d = off[0];
            end
            LT_LW: begin
                data_d  = mem_rdata;
                misal_d = (off != 2'd0);
            end
            default: data_d = mem_alu_result;
        endcase
    end

    assign retire    = !flush && !stall && mem_valid && !misal_d;
    assign instret_d = retire ? instret_q + 32'd1 : instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            wt_req_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            misal_q   <= 1'b0;
            vaddr_q   <= '0;
            instret_q <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q  <= mem_valid;
                wt_req_q <= mem_wt;
                addr_q   <= mem_wt_addr;
                data_q   <= data_d;
                misal_q  <= misal_d;
                vaddr_q  <= mem_alu_result;
            end
            instret_q <= instret_d;
        end
    end

    assign wt          = valid_q && wt_req_q && (addr_q != 5'd0) && !misal_q;
    assign fwd_valid   = wt;
    assign reg_wt_addr = addr_q;
    assign Data_in     = data_q;
    assign ade_l       = valid_q && misal_q;
    assign bad_vaddr   = vaddr_q;
    assign instret     = instret_q;

endmodule
